// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of the 8-bit synchronous data memory port. Accepts LOAD,
// STORE and multi-byte COPY requests from the core over valid/ready, drives
// registered memory strobes decoded from the FSM state, and returns a single
// cycle response pulse. COPY moves one byte every three cycles (read,
// capture, write) in ascending order. Overlapping ranges therefore replicate
// bytes, and that is the intended behaviour.
module load_store_unit #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_addr2,
   input  logic [DATA_W-1:0] req_data,
   input  logic [7:0]        req_len,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      ST_WR,
      LD_RD,
      LD_CAP,
      CP_RD,
      CP_CAP,
      CP_WR,
      RESP
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [7:0]        len_q;
   logic [7:0]        idx_q, idx_d;

   logic              mem_wen_d, mem_ren_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic              rsp_valid_d, rsp_err_d;
   logic [DATA_W-1:0] rsp_data_d;

   logic accept;

   assign req_ready = (state_q == IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign busy      = (state_q != IDLE);

   // Next state plus next values of every registered output. The memory
   // strobes are computed one step ahead so they line up with their state.
   // mem_wdata doubles as the copy byte buffer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mem_wen_d   = 1'b0;
      mem_ren_d   = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data;
      rsp_err_d   = rsp_err;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (req_op)
                  OP_LOAD: begin
                     state_d    = LD_RD;
                     mem_ren_d  = 1'b1;
                     mem_addr_d = req_addr;
                  end
                  OP_STORE: begin
                     state_d     = ST_WR;
                     mem_wen_d   = 1'b1;
                     mem_addr_d  = req_addr;
                     mem_wdata_d = req_data;
                  end
                  OP_COPY: begin
                     idx_d = 8'd0;
                     if (req_len == 8'd0) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b0;
                     end else begin
                        state_d    = CP_RD;
                        mem_ren_d  = 1'b1;
                        mem_addr_d = req_addr;
                     end
                  end
                  default: begin
                     state_d     = RESP;
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = '0;
                     rsp_err_d   = 1'b1;
                  end
               endcase
            end
         end
         ST_WR: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b0;
         end
         LD_RD: begin
            state_d = LD_CAP;
         end
         LD_CAP: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_rdata;
            rsp_err_d   = 1'b0;
         end
         CP_RD: begin
            state_d = CP_CAP;
         end
         CP_CAP: begin
            state_d     = CP_WR;
            mem_wen_d   = 1'b1;
            mem_addr_d  = dst_q + ADDR_W'(idx_q);
            mem_wdata_d = mem_rdata;
         end
         CP_WR: begin
            if (idx_q + 8'd1 == len_q) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = DATA_W'(len_q);
               rsp_err_d   = 1'b0;
            end else begin
               state_d    = CP_RD;
               idx_d      = idx_q + 8'd1;
               mem_ren_d  = 1'b1;
               mem_addr_d = src_q + ADDR_W'(idx_q + 8'd1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, request latches and registered outputs; reset abandons any
   // operation in flight without producing a response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= 8'd0;
         idx_q     <= 8'd0;
         mem_wen   <= 1'b0;
         mem_ren   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         mem_wen   <= mem_wen_d;
         mem_ren   <= mem_ren_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         rsp_err   <= rsp_err_d;
         if (accept) begin
            src_q <= req_addr;
            dst_q <= req_addr2;
            len_q <= req_len;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed bench with a behavioural 256-byte synchronous memory. Expected
// responses are queued when a request is issued and a monitor pops and
// compares them whenever rsp_valid is seen.
module tb_load_store_unit;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [7:0] req_addr;
   logic [7:0] req_addr2;
   logic [7:0] req_data;
   logic [7:0] req_len;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       busy;
   logic       mem_wen;
   logic       mem_ren;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   logic [7:0] mem [0:255];

   int errors;
   int checks;
   int cyc;
   int wen_cnt;
   int ren_cnt;
   int wen_snap;
   int ren_snap;

   load_store_unit #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_addr2 (req_addr2),
      .req_data  (req_data),
      .req_len   (req_len),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mem_wen   (mem_wen),
      .mem_ren   (mem_ren),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Free-running clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure response latency
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Synchronous memory: write has priority, read data registered
   always @(posedge clk) begin
      if (mem_wen)
         mem[mem_addr] <= mem_wdata;
      else if (mem_ren)
         mem_rdata <= mem[mem_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: strobe accounting, strobe exclusivity and scoreboard compare
   always @(negedge clk) begin
      if (mem_wen) wen_cnt++;
      if (mem_ren) ren_cnt++;
      if (!reset) checkOutput("strobe_exclusive", 32'(mem_wen && mem_ren), 32'd0);
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            checkOutput("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            checkOutput("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   // Issue one request at a negedge; optionally queue its expected response
   task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr,
                                input logic [7:0] addr2, input logic [7:0] data,
                                input logic [7:0] len, input bit want_rsp,
                                input logic [7:0] exp_data, input logic exp_err,
                                input int lat);
      int   waited;
      exp_t e;
      waited = 0;
      while (!req_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         checkOutput("req_ready_wait", 32'd0, 32'd1);
      end else begin
         req_op    = op;
         req_addr  = addr;
         req_addr2 = addr2;
         req_data  = data;
         req_len   = len;
         req_valid = 1'b1;
         if (want_rsp) begin
            e.data = exp_data;
            e.err  = exp_err;
            e.cyc  = cyc + lat;
            sb.push_back(e);
         end
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   task automatic doStore(input logic [7:0] addr, input logic [7:0] data);
      applyStimulus(OP_STORE, addr, 8'h00, data, 8'd0, 1'b1, 8'h00, 1'b0, 2);
   endtask

   // Wait for outstanding responses to drain and the FSM to return to IDLE
   task automatic waitIdle();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || busy)
         checkOutput("wait_idle_timeout", 32'd1, 32'd0);
      @(negedge clk);
   endtask

   task automatic snapStrobes();
      wen_snap = wen_cnt;
      ren_snap = ren_cnt;
   endtask

   task automatic checkStrobes(input string name, input int wens, input int rens);
      checkOutput({name, "_wen_cycles"}, 32'(wen_cnt - wen_snap), 32'(wens));
      checkOutput({name, "_ren_cycles"}, 32'(ren_cnt - ren_snap), 32'(rens));
   endtask

   // Absolute time limit so a stuck run still ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      errors    = 0;
      checks    = 0;
      cyc       = 0;
      wen_cnt   = 0;
      ren_cnt   = 0;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = OP_LOAD;
      req_addr  = 8'h00;
      req_addr2 = 8'h00;
      req_data  = 8'h00;
      req_len   = 8'd0;

      repeat (3) @(negedge clk);
      checkOutput("reset_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_mem_wen", 32'(mem_wen), 32'd0);
      checkOutput("reset_mem_ren", 32'(mem_ren), 32'd0);
      checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("idle_ready", 32'(req_ready), 32'd1);
      @(negedge clk);

      // STORE then LOAD of the same location
      snapStrobes();
      doStore(8'h10, 8'hA5);
      waitIdle();
      checkStrobes("store", 1, 0);
      checkOutput("mem_10", 32'(mem[8'h10]), 32'hA5);
      snapStrobes();
      applyStimulus(OP_LOAD, 8'h10, 8'h00, 8'h00, 8'd0, 1'b1, 8'hA5, 1'b0, 3);
      waitIdle();
      checkStrobes("load", 0, 1);

      // Four-byte COPY 0x00..0x03 -> 0x80..0x83
      doStore(8'h00, 8'h11);
      doStore(8'h01, 8'h22);
      doStore(8'h02, 8'h33);
      doStore(8'h03, 8'h44);
      waitIdle();
      snapStrobes();
      applyStimulus(OP_COPY, 8'h00, 8'h80, 8'h00, 8'd4, 1'b1, 8'd4, 1'b0, 13);
      waitIdle();
      checkStrobes("copy4", 4, 4);
      checkOutput("mem_80", 32'(mem[8'h80]), 32'h11);
      checkOutput("mem_81", 32'(mem[8'h81]), 32'h22);
      checkOutput("mem_82", 32'(mem[8'h82]), 32'h33);
      checkOutput("mem_83", 32'(mem[8'h83]), 32'h44);

      // COPY whose source wraps 0xFF -> 0x00
      doStore(8'hFE, 8'hA1);
      doStore(8'hFF, 8'hA2);
      doStore(8'h00, 8'hA3);
      waitIdle();
      applyStimulus(OP_COPY, 8'hFE, 8'h01, 8'h00, 8'd3, 1'b1, 8'd3, 1'b0, 10);
      waitIdle();
      checkOutput("mem_01", 32'(mem[8'h01]), 32'hA1);
      checkOutput("mem_02", 32'(mem[8'h02]), 32'hA2);
      checkOutput("mem_03", 32'(mem[8'h03]), 32'hA3);

      // Zero-length COPY responds on the next cycle with no strobes
      snapStrobes();
      applyStimulus(OP_COPY, 8'h05, 8'h06, 8'h00, 8'd0, 1'b1, 8'd0, 1'b0, 1);
      waitIdle();
      checkStrobes("copy0", 0, 0);

      // Overlapping COPY replicates the first byte
      doStore(8'h20, 8'h7E);
      doStore(8'h21, 8'h01);
      doStore(8'h22, 8'h02);
      doStore(8'h23, 8'h03);
      waitIdle();
      applyStimulus(OP_COPY, 8'h20, 8'h21, 8'h00, 8'd3, 1'b1, 8'd3, 1'b0, 10);
      waitIdle();
      checkOutput("mem_21", 32'(mem[8'h21]), 32'h7E);
      checkOutput("mem_22", 32'(mem[8'h22]), 32'h7E);
      checkOutput("mem_23", 32'(mem[8'h23]), 32'h7E);

      // Reserved opcode
      snapStrobes();
      applyStimulus(OP_RSVD, 8'h30, 8'h31, 8'h99, 8'd2, 1'b1, 8'h00, 1'b1, 1);
      waitIdle();
      checkStrobes("reserved", 0, 0);

      // req_valid held while busy: exactly one LOAD is accepted
      checkOutput("hold_ready_idle", 32'(req_ready), 32'd1);
      req_op    = OP_LOAD;
      req_addr  = 8'h21;
      req_addr2 = 8'h00;
      req_data  = 8'h00;
      req_len   = 8'd0;
      req_valid = 1'b1;
      mon_e.data = 8'h7E;
      mon_e.err  = 1'b0;
      mon_e.cyc  = cyc + 3;
      sb.push_back(mon_e);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("hold_ready_busy", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      waitIdle();
      repeat (5) @(negedge clk);

      // Reset during the second byte of a five-byte COPY
      doStore(8'h40, 8'h51);
      doStore(8'h41, 8'h52);
      doStore(8'h42, 8'h53);
      doStore(8'h43, 8'h54);
      doStore(8'h44, 8'h55);
      doStore(8'h60, 8'hC0);
      doStore(8'h61, 8'hC1);
      doStore(8'h62, 8'hC2);
      doStore(8'h63, 8'hC3);
      doStore(8'h64, 8'hC4);
      waitIdle();
      applyStimulus(OP_COPY, 8'h40, 8'h60, 8'h00, 8'd5, 1'b0, 8'h00, 1'b0, 0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_ready", 32'(req_ready), 32'd0);
      checkOutput("abort_mem_wen", 32'(mem_wen), 32'd0);
      checkOutput("abort_mem_ren", 32'(mem_ren), 32'd0);
      checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("abort_mem_wdata", 32'(mem_wdata), 32'd0);
      checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("abort_rsp_data", 32'(rsp_data), 32'd0);
      checkOutput("abort_rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("abort_mem_60", 32'(mem[8'h60]), 32'h51);
      checkOutput("abort_mem_61", 32'(mem[8'h61]), 32'hC1);
      checkOutput("abort_mem_62", 32'(mem[8'h62]), 32'hC2);
      checkOutput("abort_mem_63", 32'(mem[8'h63]), 32'hC3);
      checkOutput("abort_mem_64", 32'(mem[8'h64]), 32'hC4);
      applyStimulus(OP_LOAD, 8'h60, 8'h00, 8'h00, 8'd0, 1'b1, 8'h51, 1'b0, 3);
      applyStimulus(OP_LOAD, 8'h64, 8'h00, 8'h00, 8'd0, 1'b1, 8'hC4, 1'b0, 3);
      waitIdle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
